// File: rtl/easyaxi_mst_rd_arb_if.sv
// AXI read master port (AR + R) shared by the read arbiter.
// master: drives AR and rready; slave: drives arready and R.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif

interface easyaxi_mst_rd_arb_if;
    logic                      arvalid;
    logic                      arready;
    logic [`AXI_ID_W-1:0]      arid;
    logic [`AXI_ADDR_W-1:0]    araddr;
    logic [`AXI_LEN_W-1:0]     arlen;
    logic [`AXI_SIZE_W-1:0]    arsize;
    logic [`AXI_BURST_W-1:0]   arburst;
    logic [`AXI_USER_W-1:0]    aruser;
    logic                      rvalid;
    logic                      rready;
    logic [`AXI_ID_W-1:0]      rid;
    logic [`AXI_DATA_W-1:0]    rdata;
    logic [`AXI_RESP_W-1:0]    rresp;
    logic                      rlast;
    logic [`AXI_USER_W-1:0]    ruser;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, aruser,
        output rready,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast, ruser
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, aruser,
        input  rready,
        output arready,
        output rvalid, rid, rdata, rresp, rlast, ruser
    );
endinterface

// File: rtl/easyaxi_mst_rd_arb.sv
// Round-robin AR arbiter + RID router sharing one AXI read master port.
// Ports: clk/rst, per-source flattened AR/R, ost_full, route_err, idle, axi_mst.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif

module easyaxi_mst_rd_arb #(
    parameter int SRC_NUM = 4,
    parameter int SRC_W   = 2,
    parameter int LID_W   = 2,
    parameter int MAX_OST = 8,
    parameter int OST_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SRC_NUM-1:0]                src_arvalid,
    output logic [SRC_NUM-1:0]                src_arready,
    input  logic [SRC_NUM*LID_W-1:0]          src_arid,
    input  logic [SRC_NUM*`AXI_ADDR_W-1:0]    src_araddr,
    input  logic [SRC_NUM*`AXI_LEN_W-1:0]     src_arlen,
    input  logic [SRC_NUM*`AXI_SIZE_W-1:0]    src_arsize,
    input  logic [SRC_NUM*`AXI_BURST_W-1:0]   src_arburst,
    output logic [SRC_NUM-1:0]                src_rvalid,
    input  logic [SRC_NUM-1:0]                src_rready,
    output logic [LID_W-1:0]                  src_rid,
    output logic [`AXI_DATA_W-1:0]            src_rdata,
    output logic [`AXI_RESP_W-1:0]            src_rresp,
    output logic                              src_rlast,
    output logic [SRC_NUM-1:0]                src_ost_full,
    output logic                              route_err,
    output logic                              idle,
    easyaxi_mst_rd_arb_if.master              axi_mst
);

    localparam int AW = `AXI_ADDR_W;
    localparam int LW = `AXI_LEN_W;
    localparam int SW = `AXI_SIZE_W;
    localparam int BW = `AXI_BURST_W;

    typedef enum logic {S_EMPTY, S_FULL} slot_e;

    slot_e                  state;
    slot_e                  state_nx;
    logic [SRC_W-1:0]       rr_ptr;
    logic [OST_W-1:0]       cnt [SRC_NUM];
    logic [SRC_NUM-1:0]     elig;
    logic [SRC_NUM-1:0]     cnt_nz;
    logic [SRC_NUM-1:0]     dec;
    logic                   gnt_vld;
    logic [SRC_W-1:0]       gnt_idx;
    logic [SRC_W:0]         pos;
    logic                   ar_hs;
    logic                   capture;
    logic                   grant;
    logic [SRC_W-1:0]       r_idx;
    logic                   r_ok;
    logic                   r_hs;
    logic [`AXI_ID_W-1:0]   arid_q;
    logic [AW-1:0]          araddr_q;
    logic [LW-1:0]          arlen_q;
    logic [SW-1:0]          arsize_q;
    logic [BW-1:0]          arburst_q;
    logic                   unused_ok;

    always_comb begin
        for (int s = 0; s < SRC_NUM; s++) begin
            src_ost_full[s] = (cnt[s] == OST_W'(MAX_OST));
            cnt_nz[s]       = |cnt[s];
        end
    end

    assign elig = src_arvalid & ~src_ost_full;

    // Scan from the farthest offset down so the nearest eligible source
    // at or after rr_ptr is the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            pos = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (pos >= (SRC_W+1)'(SRC_NUM))
                pos = pos - (SRC_W+1)'(SRC_NUM);
            if (elig[pos[SRC_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos[SRC_W-1:0];
            end
        end
    end

    assign ar_hs   = axi_mst.arvalid & axi_mst.arready;
    assign capture = (state == S_EMPTY) | ar_hs;
    // Reset also masks the combinational accept so no source sees a
    // handshake that the slot would then discard.
    assign grant   = ~rst & capture & gnt_vld;

    assign src_arready = grant ? (SRC_NUM'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_EMPTY: if (grant) state_nx = S_FULL;
            S_FULL:  if (ar_hs && !grant) state_nx = S_EMPTY;
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else if (grant) begin
            rr_ptr    <= (int'(gnt_idx) == SRC_NUM - 1) ? '0 : gnt_idx + 1'b1;
            arid_q    <= {gnt_idx, src_arid[int'(gnt_idx)*LID_W +: LID_W]};
            araddr_q  <= src_araddr[int'(gnt_idx)*AW +: AW];
            arlen_q   <= src_arlen[int'(gnt_idx)*LW +: LW];
            arsize_q  <= src_arsize[int'(gnt_idx)*SW +: SW];
            arburst_q <= src_arburst[int'(gnt_idx)*BW +: BW];
        end
    end

    assign axi_mst.arvalid = (state == S_FULL);
    assign axi_mst.arid    = arid_q;
    assign axi_mst.araddr  = araddr_q;
    assign axi_mst.arlen   = arlen_q;
    assign axi_mst.arsize  = arsize_q;
    assign axi_mst.arburst = arburst_q;
    assign axi_mst.aruser  = '0;

    assign r_idx = axi_mst.rid[`AXI_ID_W-1 -: SRC_W];
    assign r_ok  = ({1'b0, r_idx} < (SRC_W+1)'(SRC_NUM));

    // Beats for a nonexistent source are accepted and dropped so the
    // shared R channel can never deadlock.
    assign axi_mst.rready = r_ok ? src_rready[r_idx] : 1'b1;
    assign src_rvalid     = (axi_mst.rvalid & r_ok) ? (SRC_NUM'(1) << r_idx) : '0;
    assign src_rid        = axi_mst.rid[LID_W-1:0];
    assign src_rdata      = axi_mst.rdata;
    assign src_rresp      = axi_mst.rresp;
    assign src_rlast      = axi_mst.rlast;
    assign r_hs           = axi_mst.rvalid & axi_mst.rready;

    always_comb begin
        for (int s = 0; s < SRC_NUM; s++)
            dec[s] = r_hs & axi_mst.rlast & r_ok & (r_idx == SRC_W'(s));
    end

    // Decrement at zero saturates: RLASTs of bursts issued before a
    // reset may still arrive afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SRC_NUM; s++) cnt[s] <= '0;
        end else begin
            for (int s = 0; s < SRC_NUM; s++) begin
                if (src_arready[s] && !dec[s])
                    cnt[s] <= cnt[s] + 1'b1;
                else if (dec[s] && !src_arready[s] && cnt_nz[s])
                    cnt[s] <= cnt[s] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) route_err <= 1'b0;
        else     route_err <= axi_mst.rvalid & ~r_ok;
    end

    assign idle = (state == S_EMPTY) & ~|cnt_nz;

    assign unused_ok = &{1'b0, axi_mst.ruser};

endmodule

// File: tb/tb_easyaxi_mst_rd_arb.sv
// Randomized bench for easyaxi_mst_rd_arb with a reference model and an
// AR scoreboard; R routing and status outputs are checked every cycle.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif

module tb_easyaxi_mst_rd_arb;

    localparam int N    = 4;
    localparam int MAXO = 8;
    localparam int NCYC = 2000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src_arvalid;
    logic [N-1:0]   src_arready;
    logic [N*2-1:0] src_arid;
    logic [N*32-1:0] src_araddr;
    logic [N*8-1:0] src_arlen;
    logic [N*3-1:0] src_arsize;
    logic [N*2-1:0] src_arburst;
    logic [N-1:0]   src_rvalid;
    logic [N-1:0]   src_rready;
    logic [1:0]     src_rid;
    logic [31:0]    src_rdata;
    logic [1:0]     src_rresp;
    logic           src_rlast;
    logic [N-1:0]   src_ost_full;
    logic           route_err;
    logic           idle;

    easyaxi_mst_rd_arb_if axi ();

    easyaxi_mst_rd_arb dut (
        .clk          (clk),
        .rst          (rst),
        .src_arvalid  (src_arvalid),
        .src_arready  (src_arready),
        .src_arid     (src_arid),
        .src_araddr   (src_araddr),
        .src_arlen    (src_arlen),
        .src_arsize   (src_arsize),
        .src_arburst  (src_arburst),
        .src_rvalid   (src_rvalid),
        .src_rready   (src_rready),
        .src_rid      (src_rid),
        .src_rdata    (src_rdata),
        .src_rresp    (src_rresp),
        .src_rlast    (src_rlast),
        .src_ost_full (src_ost_full),
        .route_err    (route_err),
        .idle         (idle),
        .axi_mst      (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        int         left;
    } burst_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    burst_t      pend[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: round-robin over eligible sources, slot belief,
    // per-source outstanding burst counts.
    initial begin : model
        bit          m_full;
        int          m_ptr;
        int          m_cnt [N];
        int          g;
        int          j;
        int          ridx;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_full;
        bit          all0;
        bit          cap;
        bit          r_last_hs;
        logic [1:0]  g2;
        m_full = 0;
        m_ptr  = 0;
        foreach (m_cnt[k]) m_cnt[k] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
                chk("rst_arready", 64'(src_arready), 64'd0);
                chk("rst_idle", 64'(idle), 64'd1);
                chk("rst_full", 64'(src_ost_full), 64'd0);
                chk("rst_rerr", 64'(route_err), 64'd0);
                chk("rst_payload", 64'({axi.arid, axi.araddr}), 64'd0);
                m_full = 0;
                m_ptr  = 0;
                foreach (m_cnt[k]) m_cnt[k] = 0;
                exp_q.delete();
            end else begin
                cap = !m_full || axi.arready;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && src_arvalid[j] && m_cnt[j] != MAXO) g = j;
                end
                if (!cap) g = -1;
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                all0 = 1;
                for (int k = 0; k < N; k++) begin
                    exp_full[k] = (m_cnt[k] == MAXO);
                    if (m_cnt[k] != 0) all0 = 0;
                end
                chk("src_arready", 64'(src_arready), 64'(exp_rdy));
                chk("arvalid", 64'(axi.arvalid), 64'(m_full));
                chk("ost_full", 64'(src_ost_full), 64'(exp_full));
                chk("idle", 64'(idle), 64'(!m_full && all0));
                chk("route_err", 64'(route_err), 64'd0);

                ridx = int'(axi.rid[3:2]);
                r_last_hs = axi.rvalid && src_rready[ridx] && axi.rlast;
                if (g >= 0) begin
                    g2 = 2'(g);
                    exp_q.push_back(64'({g2, src_arid[g*2 +: 2],
                        src_araddr[g*32 +: 32], src_arlen[g*8 +: 8],
                        src_arsize[g*3 +: 3], src_arburst[g*2 +: 2]}));
                    m_ptr  = (g + 1) % N;
                    m_full = 1;
                    m_cnt[g]++;
                end else if (m_full && axi.arready) begin
                    m_full = 0;
                end
                if (r_last_hs && m_cnt[ridx] > 0) m_cnt[ridx]--;
            end
        end
    end

    // Monitor: AR scoreboard pops, stall stability, R routing.
    initial begin : monitor
        bit          prev_stall;
        logic [63:0] prev_pay;
        logic [63:0] pay;
        logic [63:0] exp;
        int          ridx;
        logic [N-1:0] exp_rv;
        prev_stall = 0;
        prev_pay   = '0;
        forever begin
            @(negedge clk);
            pay = 64'({axi.arid, axi.araddr, axi.arlen, axi.arsize,
                       axi.arburst});
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) chk("ar_stable", pay, prev_pay);
                if (axi.arvalid && axi.arready) begin
                    if (exp_q.size() == 0) begin
                        chk("ar_unexpected", pay, 64'hx);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("ar_payload", pay, exp);
                    end
                end
                if (axi.arvalid) chk("aruser", 64'(axi.aruser), 64'd0);
                ridx   = int'(axi.rid[3:2]);
                exp_rv = '0;
                if (axi.rvalid) exp_rv[ridx] = 1'b1;
                chk("src_rvalid", 64'(src_rvalid), 64'(exp_rv));
                chk("rready", 64'(axi.rready), 64'(src_rready[ridx]));
                if (axi.rvalid) begin
                    chk("src_rid", 64'(src_rid), 64'(axi.rid[1:0]));
                    chk("r_pass", 64'({src_rdata, src_rresp, src_rlast}),
                        64'({axi.rdata, axi.rresp, axi.rlast}));
                end
                prev_stall = axi.arvalid && !axi.arready;
                prev_pay   = pay;
            end
        end
    end

    // Stimulus: sources, AR slave, R slave.
    initial begin : drive
        int req_pct, ar_pct, r_pct, rr_pct;
        logic [N-1:0] src_hs;
        bit ar_hs, r_hs;
        logic [3:0] hs_id;
        logic [7:0] hs_len;
        burst_t b;
        rst         = 1'b1;
        src_arvalid = '0;
        src_arid    = '0;
        src_araddr  = '0;
        src_arlen   = '0;
        src_arsize  = '0;
        src_arburst = '0;
        src_rready  = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        axi.rlast   = 1'b0;
        axi.ruser   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            src_hs = src_arvalid & src_arready;
            ar_hs  = axi.arvalid && axi.arready;
            r_hs   = axi.rvalid && axi.rready;
            hs_id  = axi.arid;
            hs_len = axi.arlen;
            @(posedge clk);
            #1;
            if (c < 300) begin
                req_pct = 50; ar_pct = 70; r_pct = 60; rr_pct = 70;
            end else if (c < 400) begin
                req_pct = 100; ar_pct = 100; r_pct = 100; rr_pct = 100;
            end else if (c < 600) begin
                req_pct = 80; ar_pct = ((c / 6) % 2 == 0) ? 100 : 0;
                r_pct = 50; rr_pct = 60;
            end else if (c < 900) begin
                req_pct = 90; ar_pct = 80; r_pct = 0; rr_pct = 50;
            end else if (c < 1300) begin
                req_pct = 40; ar_pct = 80; r_pct = 90; rr_pct = 50;
            end else begin
                req_pct = 60; ar_pct = 60; r_pct = 70; rr_pct = 70;
            end
            rst = (c >= 1300 && c < 1303);

            for (int s = 0; s < N; s++) begin
                if (src_hs[s]) src_arvalid[s] = 1'b0;
                if (!src_arvalid[s] &&
                    $urandom_range(0, 99) < 32'(req_pct)) begin
                    src_arvalid[s]           = 1'b1;
                    src_arid[s*2 +: 2]       = 2'($urandom);
                    src_araddr[s*32 +: 32]   = $urandom;
                    src_arlen[s*8 +: 8]      = 8'($urandom_range(0, 3));
                    src_arsize[s*3 +: 3]     = 3'($urandom_range(0, 5));
                    src_arburst[s*2 +: 2]    = 2'($urandom_range(0, 2));
                end
                src_rready[s] = ($urandom_range(0, 99) < 32'(rr_pct));
            end
            axi.arready = ($urandom_range(0, 99) < 32'(ar_pct));

            if (ar_hs) begin
                b.id   = hs_id;
                b.left = int'(hs_len);
                pend.push_back(b);
            end
            if (r_hs && pend.size() > 0) begin
                if (pend[0].left == 0) void'(pend.pop_front());
                else pend[0].left = pend[0].left - 1;
            end
            if (axi.rvalid && !r_hs) begin
                axi.rvalid = 1'b1;
            end else if (pend.size() > 0 &&
                         $urandom_range(0, 99) < 32'(r_pct)) begin
                axi.rvalid = 1'b1;
                axi.rid    = pend[0].id;
                axi.rlast  = (pend[0].left == 0);
                axi.rdata  = $urandom;
                axi.rresp  = 2'($urandom);
            end else begin
                axi.rvalid = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
